// File: rtl/yabot_pkg.sv
// Shared constants and types for the yabot core.
// Readback arbiter defaults and output slot state.
package yabot_pkg;

  localparam int RB_CHANNELS = 6;
  localparam int RB_WIDTH    = 28;
  localparam int RB_SEL_W    = 3;
  localparam int RB_MAX_URG  = 4;

  localparam logic [RB_CHANNELS-1:0] RB_URGENT_MASK = 6'b000010;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } rb_slot_e;

  // Search distance of channel c when the search starts at ptr+1.
  function automatic int rb_dist(int ptr, int c, int n);
    return (c - ptr - 1 + 2 * n) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: the first set request after the pointer
// wins, wrapping modulo N.
module rr_pick
  import yabot_pkg::*;
#(
  parameter int N = RB_CHANNELS
) (
  input  logic [N-1:0]          i_req,
  input  logic [RB_SEL_W-1:0]   i_ptr,
  output logic                  o_any,
  output logic [RB_SEL_W-1:0]   o_idx
);

  int w_best;
  int w_dist;

  assign o_any = |i_req;

  always_comb begin
    w_best = N;
    w_dist = 0;
    o_idx  = '0;
    for (int c = 0; c < N; c++) begin
      w_dist = rb_dist(int'(i_ptr), c, N);
      if (i_req[c] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = RB_SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/readback_arbiter.sv
// Merges per-peripheral readback words into one registered output slot.
// Urgent class wins, with a starvation guard for the normal class.
module readback_arbiter
  import yabot_pkg::*;
#(
  parameter int             N           = RB_CHANNELS,
  parameter int             W           = RB_WIDTH,
  parameter logic [N-1:0]   URGENT_MASK = RB_URGENT_MASK,
  parameter int             MAX_URG     = RB_MAX_URG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       bus_in,
  output logic [N-1:0]         busy,
  output logic                 out_stb,
  input  logic                 out_rdy,
  output logic [W-1:0]         out_data,
  output logic [RB_SEL_W-1:0]  out_sel,
  output logic                 out_urgent,
  output logic [N-1:0]         ovf,
  input  logic                 ovf_clr
);

  localparam int CW = (MAX_URG < 1) ? 1 : $clog2(MAX_URG + 1);

  rb_slot_e r_state, w_state_nxt;

  logic [W-1:0]         r_hold [N];
  logic [N-1:0]         r_pend;
  logic [N-1:0]         r_ovf;
  logic [RB_SEL_W-1:0]  r_ptr_u;
  logic [RB_SEL_W-1:0]  r_ptr_l;
  logic [CW-1:0]        r_urg_cnt;
  logic [W-1:0]         r_data;
  logic [RB_SEL_W-1:0]  r_sel;
  logic                 r_urgent;

  logic [N-1:0]         w_u;
  logic [N-1:0]         w_l;
  logic                 w_u_any;
  logic                 w_l_any;
  logic [RB_SEL_W-1:0]  w_u_idx;
  logic [RB_SEL_W-1:0]  w_l_idx;
  logic                 w_starve;
  logic                 w_gnt_en;
  logic                 w_gnt_urg;
  logic                 w_gnt;
  logic [RB_SEL_W-1:0]  w_gnt_idx;
  logic [N-1:0]         w_gnt_oh;
  logic [W-1:0]         w_gnt_data;
  logic [CW-1:0]        w_cnt_nxt;

  assign w_u = r_pend & URGENT_MASK;
  assign w_l = r_pend & ~URGENT_MASK;

  rr_pick #(.N(N)) u_pick_u (
    .i_req (w_u),
    .i_ptr (r_ptr_u),
    .o_any (w_u_any),
    .o_idx (w_u_idx)
  );

  rr_pick #(.N(N)) u_pick_l (
    .i_req (w_l),
    .i_ptr (r_ptr_l),
    .o_any (w_l_any),
    .o_idx (w_l_idx)
  );

  always_comb begin
    w_starve   = (r_urg_cnt == CW'(MAX_URG)) && w_l_any;
    w_gnt_en   = (r_state == SLOT_EMPTY) || out_rdy;
    w_gnt_urg  = w_u_any && !w_starve;
    w_gnt      = w_gnt_en && (w_gnt_urg || w_l_any);
    w_gnt_idx  = w_gnt_urg ? w_u_idx : w_l_idx;
    w_gnt_oh   = '0;
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt && (w_gnt_idx == RB_SEL_W'(i))) begin
        w_gnt_oh[i] = 1'b1;
        w_gnt_data  = r_hold[i];
      end
    end
  end

  // Count only urgent grants that overtake a waiting normal channel.
  always_comb begin
    w_cnt_nxt = r_urg_cnt;
    if (!w_l_any) begin
      w_cnt_nxt = '0;
    end else if (w_gnt && !w_gnt_urg) begin
      w_cnt_nxt = '0;
    end else if (w_gnt && (r_urg_cnt != CW'(MAX_URG))) begin
      w_cnt_nxt = r_urg_cnt + CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SLOT_EMPTY: if (w_gnt) w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (out_rdy && !w_gnt) w_state_nxt = SLOT_EMPTY;
      default:    w_state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) r_hold[i] <= '0;
      r_pend    <= '0;
      r_ovf     <= '0;
      r_ptr_u   <= RB_SEL_W'(N - 1);
      r_ptr_l   <= RB_SEL_W'(N - 1);
      r_urg_cnt <= '0;
      r_data    <= '0;
      r_sel     <= '0;
      r_urgent  <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && (!r_pend[i] || w_gnt_oh[i])) begin
          r_hold[i] <= bus_in[i*W +: W];
        end
      end
      r_pend    <= (r_pend & ~w_gnt_oh) | req;
      r_ovf     <= (r_ovf & ~{N{ovf_clr}})
                 | (req & r_pend & ~w_gnt_oh);
      r_urg_cnt <= w_cnt_nxt;
      if (w_gnt) begin
        r_data   <= w_gnt_data;
        r_sel    <= w_gnt_idx;
        r_urgent <= w_gnt_urg;
        if (w_gnt_urg) begin
          r_ptr_u <= w_gnt_idx;
        end else begin
          r_ptr_l <= w_gnt_idx;
        end
      end
    end
  end

  assign busy       = r_pend;
  assign ovf        = r_ovf;
  assign out_stb    = (r_state == SLOT_FULL);
  assign out_data   = r_data;
  assign out_sel    = r_sel;
  assign out_urgent = r_urgent;

endmodule
